// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: mm:ss stopwatch with pause, clear and per-field adjust mode
module stopwatch_ctrl #(
  parameter int MIN_MAX = 59,
  parameter int SEC_MAX = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       tick_adj,
  input  logic       btn_pause,
  input  logic       btn_clear,
  input  logic       adj,
  input  logic       sel,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       paused,
  output logic [1:0] adj_state,
  output logic       blink
);
  typedef enum logic [1:0] {RUN, HOLD, ADJ_MIN, ADJ_SEC} state_t;
  state_t      r_state, w_state_nx;
  logic [5:0]  r_min, r_sec, w_min_nx, w_sec_nx, w_min_inc, w_sec_inc;
  logic        r_paused, w_paused_nx, r_blink, w_blink_nx;
  logic [1:0]  r_adj_state, w_adj_nx;
  logic        r_pause_d, r_clear_d, r_armed;
  logic        w_pause_press, w_clr_press, w_in_adj, w_nx_adj;
  // r_armed masks the first edge after reset so a button already held high is not a press
  assign w_pause_press = btn_pause & ~r_pause_d & r_armed;
  assign w_clr_press   = btn_clear & ~r_clear_d & r_armed;
  assign w_in_adj      = (r_state == ADJ_MIN) || (r_state == ADJ_SEC);
  assign w_nx_adj      = (w_state_nx == ADJ_MIN) || (w_state_nx == ADJ_SEC);
  assign w_min_inc     = (r_min == 6'(MIN_MAX)) ? 6'd0 : r_min + 6'd1;
  assign w_sec_inc     = (r_sec == 6'(SEC_MAX)) ? 6'd0 : r_sec + 6'd1;
  assign min           = r_min;
  assign sec           = r_sec;
  assign paused        = r_paused;
  assign adj_state     = r_adj_state;
  assign blink         = r_blink;
  // next state, counts and flags; r_paused doubles as the remembered pre-adjust value
  always_comb begin
    w_state_nx  = r_state;
    w_paused_nx = r_paused;
    w_min_nx    = r_min;
    w_sec_nx    = r_sec;
    if (w_in_adj) begin
      if (w_clr_press) w_paused_nx = 1'b0;
      if (!adj) w_state_nx = w_paused_nx ? HOLD : RUN;
      else w_state_nx = sel ? ADJ_SEC : ADJ_MIN;
      if (tick_adj && r_state == ADJ_MIN) w_min_nx = w_min_inc;
      if (tick_adj && r_state == ADJ_SEC) w_sec_nx = w_sec_inc;
    end else begin
      if (w_clr_press) begin
        w_paused_nx = 1'b0;
        w_state_nx  = RUN;
      end else if (w_pause_press) begin
        w_paused_nx = ~r_paused;
        w_state_nx  = r_paused ? RUN : HOLD;
      end
      if (adj) w_state_nx = sel ? ADJ_SEC : ADJ_MIN;
      if (tick_1hz && r_state == RUN) begin
        w_sec_nx = w_sec_inc;
        if (r_sec == 6'(SEC_MAX)) w_min_nx = w_min_inc;
      end
    end
    if (w_clr_press) begin
      w_min_nx = 6'd0;
      w_sec_nx = 6'd0;
    end
    w_blink_nx = (w_in_adj && w_nx_adj) ? r_blink ^ tick_adj : 1'b0;
    w_adj_nx   = (w_state_nx == ADJ_SEC) ? 2'b11 : (w_state_nx == ADJ_MIN) ? 2'b10 : 2'b00;
  end
  // state and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= RUN;
      r_min       <= 6'd0;
      r_sec       <= 6'd0;
      r_paused    <= 1'b0;
      r_blink     <= 1'b0;
      r_adj_state <= 2'b00;
      r_pause_d   <= 1'b0;
      r_clear_d   <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_min       <= w_min_nx;
      r_sec       <= w_sec_nx;
      r_paused    <= w_paused_nx;
      r_blink     <= w_blink_nx;
      r_adj_state <= w_adj_nx;
      r_pause_d   <= btn_pause;
      r_clear_d   <= btn_clear;
      r_armed     <= 1'b1;
    end
  end
endmodule
